// File: rtl/ex_fwd_alu.sv
// Execute stage with operand forwarding, load-use interlock and optional
// iterative multiplier.
// Build option: define EX_MUL_EN to enable the MUL opcode (32-cycle shift-add).
module ex_fwd_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imm_in,
  input  logic [31:0] val_rs_in,
  input  logic [31:0] val_rt_in,
  input  logic [4:0]  rwd_in,
  input  logic [5:0]  opcode_in,
  input  logic [2:0]  rs_fwd,
  input  logic [2:0]  rt_fwd,
  input  logic [31:0] alu_out_from_mem,
  input  logic [31:0] mem_data_from_mem,
  output logic [31:0] alu_res_out,
  output logic [31:0] val_rt_out,
  output logic [4:0]  rwd_out,
  output logic [5:0]  opcode_out,
  output logic        stall_out
);

  localparam logic [5:0] OP_ADD    = 6'h01;
  localparam logic [5:0] OP_SUB    = 6'h02;
  localparam logic [5:0] OP_AND    = 6'h03;
  localparam logic [5:0] OP_OR     = 6'h04;
  localparam logic [5:0] OP_SLT    = 6'h05;
  localparam logic [5:0] OP_LDW    = 6'h06;
  localparam logic [5:0] OP_SDW    = 6'h07;
  localparam logic [5:0] OP_BEQ    = 6'h08;
  localparam logic [5:0] OP_JUMP   = 6'h09;
  localparam logic [5:0] OP_BUBBLE = 6'h3F;
`ifdef EX_MUL_EN
  localparam logic [5:0] OP_MUL    = 6'h0A;

  typedef enum logic [1:0] {RUN, REPLAY, MUL_BUSY} state_t;
`else
  typedef enum logic [1:0] {RUN, REPLAY} state_t;
`endif

  state_t      state, state_nxt;
  logic [2:0]  rs_code, rt_code;
  logic [31:0] rs_sel, rt_sel, result;
  logic        load_use, mul_accept;

`ifdef EX_MUL_EN
  logic [31:0] mul_a, mul_b, mul_acc, mul_sum;
  logic [5:0]  mul_cnt;
  logic [4:0]  mul_rwd;
  logic        mul_done;
`endif

  // Operand forwarding; in replay the producing load has moved on, so code 1 means code 2
  always_comb begin
    rs_code = rs_fwd;
    rt_code = rt_fwd;
    if (state == REPLAY && rs_fwd == 3'd1) rs_code = 3'd2;
    if (state == REPLAY && rt_fwd == 3'd1) rt_code = 3'd2;
    case (rs_code)
      3'd1:    rs_sel = alu_out_from_mem;
      3'd2:    rs_sel = mem_data_from_mem;
      default: rs_sel = val_rs_in;
    endcase
    case (rt_code)
      3'd1:    rt_sel = alu_out_from_mem;
      3'd2:    rt_sel = mem_data_from_mem;
      default: rt_sel = val_rt_in;
    endcase
  end

  // Single-cycle ALU result
  always_comb begin
    result = '0;
    case (opcode_in)
      OP_ADD:         result = rs_sel + rt_sel;
      OP_SUB:         result = rs_sel - rt_sel;
      OP_AND:         result = rs_sel & rt_sel;
      OP_OR:          result = rs_sel | rt_sel;
      OP_SLT:         result = {31'd0, $signed(rs_sel) < $signed(rt_sel)};
      OP_LDW, OP_SDW: result = rs_sel + imm_in;
      OP_BEQ:         result = {31'd0, rs_sel == rt_sel};
      OP_JUMP:        result = imm_in;
      default:        result = '0;
    endcase
  end

  // Next-state, interlock and stall decode
  always_comb begin
    state_nxt  = state;
    load_use   = (state == RUN) && (opcode_out == OP_LDW) && (rwd_out != '0) &&
                 (rs_fwd == 3'd1 || rt_fwd == 3'd1);
    mul_accept = 1'b0;
    stall_out  = load_use;
`ifdef EX_MUL_EN
    mul_done   = (state == MUL_BUSY) && (mul_cnt == 6'd1);
    mul_accept = (opcode_in == OP_MUL) &&
                 ((state == RUN && !load_use) || state == REPLAY);
    if (state == MUL_BUSY) stall_out = 1'b1;
`endif
    case (state)
      RUN: begin
        if (load_use)        state_nxt = REPLAY;
        else if (mul_accept) state_nxt = state_t'(2);
      end
      REPLAY: state_nxt = mul_accept ? state_t'(2) : RUN;
      default: begin
`ifdef EX_MUL_EN
        if (mul_done) state_nxt = RUN;
`else
        state_nxt = RUN;
`endif
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

`ifdef EX_MUL_EN
  assign mul_sum = mul_acc + (mul_b[0] ? mul_a : '0);

  // Shift-add multiplier, one multiplier bit per edge
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      mul_cnt <= '0;
      mul_rwd <= '0;
    end else if (mul_accept) begin
      mul_a   <= rs_sel;
      mul_b   <= rt_sel;
      mul_acc <= '0;
      mul_cnt <= 6'd32;
      mul_rwd <= rwd_in;
    end else if (state == MUL_BUSY) begin
      mul_acc <= mul_sum;
      mul_a   <= mul_a << 1;
      mul_b   <= mul_b >> 1;
      mul_cnt <= mul_cnt - 6'd1;
    end
  end
`endif

  // Output pipeline register; the product retires on the edge that ends the
  // last busy cycle, every other stalled edge issues a bubble
  always_ff @(posedge clk) begin
    if (rst || load_use || mul_accept) begin
      alu_res_out <= '0;
      val_rt_out  <= '0;
      rwd_out     <= '0;
      opcode_out  <= OP_BUBBLE;
`ifdef EX_MUL_EN
    end else if (state == MUL_BUSY) begin
      alu_res_out <= mul_done ? mul_sum : '0;
      val_rt_out  <= '0;
      rwd_out     <= mul_done ? mul_rwd : '0;
      opcode_out  <= mul_done ? OP_MUL : OP_BUBBLE;
`endif
    end else begin
      alu_res_out <= result;
      val_rt_out  <= rt_sel;
      rwd_out     <= rwd_in;
      opcode_out  <= opcode_in;
    end
  end

endmodule

// File: tb/tb_ex_fwd_alu.sv
// Self-checking bench for ex_fwd_alu: directed cases, then random
// instruction stream checked against an instruction-level reference model.
module tb_ex_fwd_alu;

  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_SLT  = 6'h05;
  localparam logic [5:0] OP_LDW  = 6'h06;
  localparam logic [5:0] OP_SDW  = 6'h07;
  localparam logic [5:0] OP_BEQ  = 6'h08;
  localparam logic [5:0] OP_JUMP = 6'h09;
  localparam logic [5:0] OP_MUL  = 6'h0A;
  localparam logic [5:0] OP_BUB  = 6'h3F;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imm_in, val_rs_in, val_rt_in, alu_out_from_mem, mem_data_from_mem;
  logic [4:0]  rwd_in;
  logic [5:0]  opcode_in;
  logic [2:0]  rs_fwd, rt_fwd;
  logic [31:0] alu_res_out, val_rt_out;
  logic [4:0]  rwd_out;
  logic [5:0]  opcode_out;
  logic        stall_out;

  int tests = 0;
  int fails = 0;

  // Reference view of the last issued instruction
  logic [5:0] prev_op;
  logic [4:0] prev_rwd;

  ex_fwd_alu dut (
    .clk(clk), .rst(rst), .imm_in(imm_in), .val_rs_in(val_rs_in),
    .val_rt_in(val_rt_in), .rwd_in(rwd_in), .opcode_in(opcode_in),
    .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .alu_out_from_mem(alu_out_from_mem),
    .mem_data_from_mem(mem_data_from_mem), .alu_res_out(alu_res_out),
    .val_rt_out(val_rt_out), .rwd_out(rwd_out), .opcode_out(opcode_out),
    .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick(input logic [2:0] code, input logic [31:0] regv,
                                       input logic [31:0] alu_m, input logic [31:0] mem_m);
    if (code == 3'd1) return alu_m;
    if (code == 3'd2) return mem_m;
    return regv;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    case (op)
      OP_ADD:         return a + b;
      OP_SUB:         return a - b;
      OP_AND:         return a & b;
      OP_OR:          return a | b;
      OP_SLT:         return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_LDW, OP_SDW: return a + imm;
      OP_BEQ:         return (a == b) ? 32'd1 : 32'd0;
      OP_JUMP:        return imm;
      default:        return 32'd0;
    endcase
  endfunction

  task automatic check_bubble(input string tag);
    chk({tag, ".op"},  {26'd0, opcode_out}, {26'd0, OP_BUB});
    chk({tag, ".rwd"}, {27'd0, rwd_out}, 32'd0);
    chk({tag, ".res"}, alu_res_out, 32'd0);
    chk({tag, ".rt"},  val_rt_out, 32'd0);
  endtask

  // Present one instruction as decode would, holding it through any interlock.
  task automatic issue(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic [4:0] rwd,
                       input logic [2:0] rsf, input logic [2:0] rtf,
                       input logic [31:0] alu_m, input logic [31:0] mem_m,
                       input logic [31:0] mem_replay);
    logic       lu;
    logic [2:0] ers, ert;
    logic [31:0] a, b;
    opcode_in = op; val_rs_in = rs; val_rt_in = rt; imm_in = imm; rwd_in = rwd;
    rs_fwd = rsf; rt_fwd = rtf; alu_out_from_mem = alu_m; mem_data_from_mem = mem_m;
    #1;
    lu = (prev_op == OP_LDW) && (prev_rwd != 5'd0) && (rsf == 3'd1 || rtf == 3'd1);
    chk("stall", {31'd0, stall_out}, {31'd0, lu});
    ers = rsf; ert = rtf;
    if (lu) begin
      tick();
      check_bubble("lu_bubble");
      mem_data_from_mem = mem_replay;
      mem_m = mem_replay;
      #1;
      chk("replay_stall", {31'd0, stall_out}, 32'd0);
      if (ers == 3'd1) ers = 3'd2;
      if (ert == 3'd1) ert = 3'd2;
    end
    a = pick(ers, rs, alu_m, mem_m);
    b = pick(ert, rt, alu_m, mem_m);
    tick();
    chk("res", alu_res_out, alu_ref(op, a, b, imm));
    chk("rt_out", val_rt_out, b);
    chk("rwd", {27'd0, rwd_out}, {27'd0, rwd});
    chk("op", {26'd0, opcode_out}, {26'd0, op});
    prev_op = op;
    prev_rwd = rwd;
  endtask

  initial begin
    logic [5:0] ops [10];
    logic [2:0] rsf, rtf;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_LDW, OP_SDW, OP_BEQ, OP_JUMP, 6'h2A};

    rst = 1'b1; opcode_in = OP_ADD; val_rs_in = '0; val_rt_in = '0; imm_in = '0;
    rwd_in = '0; rs_fwd = '0; rt_fwd = '0; alu_out_from_mem = '0; mem_data_from_mem = '0;
    tick();
    tick();
    rst = 1'b0;
    check_bubble("reset");
    chk("reset_stall", {31'd0, stall_out}, 32'd0);
    prev_op = OP_BUB; prev_rwd = 5'd0;

    // Directed cases
    issue(OP_ADD, 32'd5, 32'd7, 32'd0, 5'd4, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    chk("add_5_7", alu_res_out, 32'd12);
    issue(OP_ADD, 32'd3, 32'd1, 32'd0, 5'd6, 3'd1, 3'd0, 32'd100, 32'd0, 32'd0);
    chk("fwd1", alu_res_out, 32'd101);
    issue(OP_ADD, 32'd3, 32'd1, 32'd0, 5'd6, 3'd2, 3'd0, 32'd0, 32'd40, 32'd40);
    chk("fwd2", alu_res_out, 32'd41);
    issue(OP_LDW, 32'd16, 32'd0, 32'd4, 5'd3, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    issue(OP_ADD, 32'd77, 32'd1, 32'd0, 5'd8, 3'd1, 3'd0, 32'd55, 32'd0, 32'd9);
    chk("load_use_replay", alu_res_out, 32'd10);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    chk("slt_neg", alu_res_out, 32'd1);
    issue(OP_SUB, 32'd0, 32'd1, 32'd0, 5'd1, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    chk("sub_wrap", alu_res_out, 32'hFFFF_FFFF);
    issue(OP_BEQ, 32'd4, 32'd4, 32'd0, 5'd0, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    chk("beq_eq", alu_res_out, 32'd1);
    issue(OP_JUMP, 32'd9, 32'd9, 32'h20, 5'd0, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    chk("jump", alu_res_out, 32'h20);
    // Load to r0 never interlocks
    issue(OP_LDW, 32'd1, 32'd0, 32'd1, 5'd0, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    issue(OP_ADD, 32'd1, 32'd2, 32'd0, 5'd2, 3'd1, 3'd1, 32'd30, 32'd50, 32'd50);

`ifdef EX_MUL_EN
    issue(OP_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    opcode_in = OP_MUL; val_rs_in = 32'd6; val_rt_in = 32'd7; rwd_in = 5'd5;
    rs_fwd = 3'd0; rt_fwd = 3'd0;
    #1;
    chk("mul_accept_stall", {31'd0, stall_out}, 32'd0);
    tick();
    check_bubble("mul_b0");
    for (int i = 0; i < 32; i++) begin
      chk("mul_stall", {31'd0, stall_out}, 32'd1);
      if (i < 31) begin
        tick();
        chk("mul_bubble", {26'd0, opcode_out}, {26'd0, OP_BUB});
      end
    end
    tick();
    chk("mul_res", alu_res_out, 32'd42);
    chk("mul_rwd", {27'd0, rwd_out}, 32'd5);
    chk("mul_op", {26'd0, opcode_out}, {26'd0, OP_MUL});
    chk("mul_end_stall", {31'd0, stall_out}, 32'd0);
    // Abort a multiply with reset
    opcode_in = OP_MUL;
    tick();
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    opcode_in = OP_ADD;
    #1;
    check_bubble("mul_abort");
    chk("mul_abort_stall", {31'd0, stall_out}, 32'd0);
    prev_op = OP_BUB; prev_rwd = 5'd0;
    issue(OP_ADD, 32'd2, 32'd3, 32'd0, 5'd9, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    chk("post_abort_add", alu_res_out, 32'd5);
`else
    issue(OP_MUL, 32'd6, 32'd7, 32'd0, 5'd5, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    chk("mul_disabled", alu_res_out, 32'd0);
`endif

    // Random instruction stream
    for (int n = 0; n < 80; n++) begin
      rsf = ($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      rtf = ($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      issue(ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom,
            5'($urandom_range(0, 31)), rsf, rtf, $urandom, $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_fwd_alu.md
EX_FWD_ALU -- requirements
Module: ex_fwd_alu

Interface
REQ-001 SHALL have ports, clock and reset first, one per line:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- imm_in  in  32  sign-extended immediate from decode
- val_rs_in / val_rt_in  in  32 each  register-file operands
- rwd_in  in  5  destination register (0 = none)
- opcode_in  in  6  instruction opcode (def.v codes)
- rs_fwd / rt_fwd  in  3 each  forwarding select: 1 = previous instr, 2 = instr two back, other = register value
- alu_out_from_mem  in  32  ALU result now in MEM
- mem_data_from_mem  in  32  load/writeback data now leaving MEM
- alu_res_out  out  32  registered result
- val_rt_out  out  32  forwarded rt, registered (store data)
- rwd_out  out  5  registered destination
- opcode_out  out  6  registered opcode
- stall_out  out  1  combinational; high = decode holds all inputs next cycle
REQ-002 SHALL use bubble opcode 6'h3F.

Function
REQ-003 Operand select: code 1 -> alu_out_from_mem; code 2 -> mem_data_from_mem; codes 0 and 3-7 -> val_*_in.
REQ-004 Result: ADD rs+rt; SUB rs-rt; AND; OR; SLT signed rs<rt -> 1/0; LDW/SDW rs+imm_in; BEQ (rs==rt) -> 1/0; JUMP imm_in; others -> 0. Arithmetic 32-bit modulo, no overflow flag.
REQ-005 Normal latency: one cycle, inputs at edge N appear on outputs after edge N.
REQ-006 Load-use: when opcode_out==LDW and rwd_out!=0 and (rs_fwd==1 or rt_fwd==1), stall_out SHALL be 1 that cycle and the next edge SHALL issue a bubble (rwd_out=0, opcode_out=6'h3F, alu_res_out=0, val_rt_out=0).
REQ-007 Replay cycle after load-use: inputs held; any code 1 SHALL be treated as code 2; stall_out 0; instruction issues normally.
REQ-008 States: RUN, REPLAY, MUL_BUSY. RUN->REPLAY on load-use; REPLAY->RUN after one edge; RUN->MUL_BUSY on MUL accept; MUL_BUSY->RUN when count reaches 0.
REQ-009 Load-use and MUL present together: load-use SHALL be resolved first; MUL SHALL be accepted in REPLAY.
REQ-010 While stall_out is 1, every edge SHALL issue a bubble.

Reset
REQ-011 rst at an edge SHALL set alu_res_out, val_rt_out, rwd_out to 0, opcode_out to 6'h3F and state to RUN, abort any multiply, clear the replay flag; rst has priority over all events.
REQ-012 stall_out SHALL be 0 in the cycle following reset.

Configuration
REQ-013 Macro EX_MUL_EN: when defined, opcode MUL is supported. On accept, the block SHALL latch the forwarded operands, enter MUL_BUSY with stall_out=1 for 32 cycles (shift-add, one bit per edge, bubbles issued), and issue the low 32 bits of rs*rt on the 33rd edge with the held rwd_in.
REQ-014 Without EX_MUL_EN: MUL SHALL complete in one cycle with alu_res_out=0, MUL_BUSY is absent, and stall_out SHALL depend only on load-use.

Verification
REQ-015 ADD rs=5, rt=7, fwd 0/0 -> next edge alu_res_out=12, rwd_out=rwd_in, stall_out=0.
REQ-016 ADD rs_fwd=1 with alu_out_from_mem=100, val_rt=1 -> 101; rs_fwd=2 with mem_data_from_mem=40 -> 41.
REQ-017 LDW r3 issued, then ADD with rs_fwd=1 -> stall_out=1 for one cycle, bubble (opcode 6'h3F, rwd 0), then replay using mem_data_from_mem=9 with rt=1 -> 10.
REQ-018 SLT rs=32'hFFFFFFFF, rt=1 -> 1; SUB 0-1 -> 32'hFFFFFFFF; BEQ 4,4 -> 1; JUMP imm=32'h20 -> 32'h20.
REQ-019 EX_MUL_EN: MUL 6*7 -> stall_out high 32 cycles, 32 bubbles, result 42 on edge 33; rst at cycle 10 -> outputs at reset values, stall_out 0, next ADD works.
REQ-020 Without EX_MUL_EN: MUL 6*7 -> alu_res_out=0 after one edge, stall_out never 1.
